// File: rtl/demod_conj_mult_pkg.sv
// Shared constants, FSM state encoding and the dequantize helper for the FM demod
// conjugate-multiply stage and its reusable complex multiplier.
package demod_conj_mult_pkg;

    localparam int QUANT_BITS_DEFAULT = 10;
    localparam int DEQ_W              = 64;

    typedef logic [2:0] demod_state_t;

    localparam demod_state_t ST_IDLE  = 3'd0;
    localparam demod_state_t ST_MULT  = 3'd1;
    localparam demod_state_t ST_SUM   = 3'd2;
    localparam demod_state_t ST_ISSUE = 3'd3;
    localparam demod_state_t ST_WAIT  = 3'd4;

    // Keep only the low 'width' bits of the product (sign-extended), then shift
    // arithmetically, so the result matches a width-bit signed multiply + >>>.
    function automatic logic [DEQ_W-1:0] dequantize(input logic [DEQ_W-1:0] prod,
                                                    input int width,
                                                    input int qbits);
        logic [DEQ_W-1:0] lo;
        for (int b = 0; b < DEQ_W; b++) begin
            lo[b] = (b < width) ? prod[b] : prod[width-1];
        end
        return $signed(lo) >>> qbits;
    endfunction

endpackage

// File: rtl/demod_conj_mult_cmul_deq.sv
// Registered four-product complex multiply with dequantization; also shared with
// the downstream gain stage. Products update only when en is high.
module demod_conj_mult_cmul_deq
    import demod_conj_mult_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = QUANT_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] a_q,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] b_q,
    output logic [DATA_WIDTH-1:0] p_ii,
    output logic [DATA_WIDTH-1:0] p_qq,
    output logic [DATA_WIDTH-1:0] p_qi,
    output logic [DATA_WIDTH-1:0] p_iq
);

    logic signed [DEQ_W-1:0] m_ii;
    logic signed [DEQ_W-1:0] m_qq;
    logic signed [DEQ_W-1:0] m_qi;
    logic signed [DEQ_W-1:0] m_iq;

    assign m_ii = DEQ_W'($signed(a_i)) * DEQ_W'($signed(b_i));
    assign m_qq = DEQ_W'($signed(a_q)) * DEQ_W'($signed(b_q));
    assign m_qi = DEQ_W'($signed(a_q)) * DEQ_W'($signed(b_i));
    assign m_iq = DEQ_W'($signed(a_i)) * DEQ_W'($signed(b_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            p_ii <= '0;
            p_qq <= '0;
            p_qi <= '0;
            p_iq <= '0;
        end else if (en) begin
            p_ii <= DATA_WIDTH'(dequantize(m_ii, DATA_WIDTH, QUANT_BITS));
            p_qq <= DATA_WIDTH'(dequantize(m_qq, DATA_WIDTH, QUANT_BITS));
            p_qi <= DATA_WIDTH'(dequantize(m_qi, DATA_WIDTH, QUANT_BITS));
            p_iq <= DATA_WIDTH'(dequantize(m_iq, DATA_WIDTH, QUANT_BITS));
        end
    end

endmodule

// File: rtl/demod_conj_mult.sv
// FM demod conjugate product (cur * conj(prev)) feeding the arctangent unit.
// Optional WAIT abort timer enabled by defining DEMOD_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | ready for a sample; clear zeroes the stored previous sample
// ST_MULT  | four dequantized partial products registered
// ST_SUM   | x/y formed, current sample becomes previous
// ST_ISSUE | start_out pulse scheduled
// ST_WAIT  | x/y held until arctan_valid (or abort timer expiry)
module demod_conj_mult
    import demod_conj_mult_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int QUANT_BITS   = QUANT_BITS_DEFAULT,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  start_out,
    input  logic                  arctan_valid,
    output logic                  timeout_err
);

    demod_state_t          state;
    logic [DATA_WIDTH-1:0] cur_i;
    logic [DATA_WIDTH-1:0] cur_q;
    logic [DATA_WIDTH-1:0] prev_i;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] p_ii;
    logic [DATA_WIDTH-1:0] p_qq;
    logic [DATA_WIDTH-1:0] p_qi;
    logic [DATA_WIDTH-1:0] p_iq;

    assign in_ready = (state == ST_IDLE) && !clear;

    demod_conj_mult_cmul_deq #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUANT_BITS (QUANT_BITS)
    ) u_cmul_deq (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_MULT),
        .a_i   (cur_i),
        .a_q   (cur_q),
        .b_i   (prev_i),
        .b_q   (prev_q),
        .p_ii  (p_ii),
        .p_qq  (p_qq),
        .p_qi  (p_qi),
        .p_iq  (p_iq)
    );

`ifdef DEMOD_TIMEOUT_EN
    localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);
    logic [TMR_W-1:0] wait_cnt;
    logic             timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cur_i     <= '0;
            cur_q     <= '0;
            prev_i    <= '0;
            prev_q    <= '0;
            x_out     <= '0;
            y_out     <= '0;
            start_out <= 1'b0;
`ifdef DEMOD_TIMEOUT_EN
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            start_out <= 1'b0;
`ifdef DEMOD_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        prev_i <= '0;
                        prev_q <= '0;
                    end else if (in_valid) begin
                        cur_i <= i_in;
                        cur_q <= q_in;
                        state <= ST_MULT;
                    end
                end
                ST_MULT: state <= ST_SUM;
                ST_SUM: begin
                    x_out  <= p_ii + p_qq;
                    y_out  <= p_qi - p_iq;
                    prev_i <= cur_i;
                    prev_q <= cur_q;
                    state  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    start_out <= 1'b1;
`ifdef DEMOD_TIMEOUT_EN
                    wait_cnt  <= TMR_W'(WAIT_TIMEOUT - 1);
`endif
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (arctan_valid) begin
                        state <= ST_IDLE;
                    end
`ifdef DEMOD_TIMEOUT_EN
                    // Down-counter hits zero on the WAIT_TIMEOUT-th wait cycle.
                    else if (wait_cnt == '0) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demod_conj_mult.sv
// Directed self-checking bench for demod_conj_mult; the abort-timer section
// follows the DEMOD_TIMEOUT_EN define shared with the RTL build.
module tb_demod_conj_mult;

    localparam int DW = 32;

    logic          clk          = 1'b0;
    logic          reset        = 1'b0;
    logic [DW-1:0] i_in         = '0;
    logic [DW-1:0] q_in         = '0;
    logic          in_valid     = 1'b0;
    logic          clear        = 1'b0;
    logic          arctan_valid = 1'b0;
    logic          in_ready;
    logic          start_out;
    logic          timeout_err;
    logic [DW-1:0] x_out;
    logic [DW-1:0] y_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demod_conj_mult dut (
        .clk          (clk),
        .reset        (reset),
        .i_in         (i_in),
        .q_in         (q_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clear        (clear),
        .x_out        (x_out),
        .y_out        (y_out),
        .start_out    (start_out),
        .arctan_valid (arctan_valid),
        .timeout_err  (timeout_err)
    );

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present one sample, then count edges until start_out is seen (bounded).
    task automatic accept_only(input string tag, input logic signed [31:0] si,
                               input logic signed [31:0] sq, output int lat);
        @(negedge clk);
        check_val({tag, " ready"}, in_ready, 1);
        i_in     = si;
        q_in     = sq;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val({tag, " busy0"}, in_ready, 0);
        lat = 0;
        while (start_out !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_sample(input string tag, input logic signed [31:0] si,
                              input logic signed [31:0] sq, input logic signed [31:0] ex,
                              input logic signed [31:0] ey);
        int lat;
        accept_only(tag, si, sq, lat);
        check_val({tag, " lat"}, lat, 3);
        check_val({tag, " x"}, x_out, ex);
        check_val({tag, " y"}, y_out, ey);
        @(posedge clk);
        #1;
        check_val({tag, " pulse"}, start_out, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, " busy"}, in_ready, 0);
        arctan_valid = 1'b1;
        @(posedge clk);
        #1;
        arctan_valid = 1'b0;
        check_val({tag, " release"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        int hits;
        int rdy;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst x", x_out, 0);
        check_val("rst y", y_out, 0);
        check_val("rst start", start_out, 0);
        check_val("rst terr", timeout_err, 0);
        check_val("rst ready", in_ready, 1);
        reset = 1'b1;

        run_sample("s1", 1024, 0, 0, 0);
        run_sample("s2", 1024, 0, 1024, 0);
        run_sample("s3", 0, 1024, 0, 1024);
        run_sample("s4", -1024, 0, 0, 1024);
        run_sample("s5", 512, 512, -512, -512);
        run_sample("s6", 3, -5, -2, -4);
        run_sample("s7", 32'sh4000_0000, 0, -1048576, 1048576);
        run_sample("s8", 1024, 0, 0, 0);

        // clear beats in_valid; previous sample is zeroed
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        i_in     = 555;
        q_in     = 777;
        #1;
        check_val("clr ready", in_ready, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        hits = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (start_out) hits++;
        end
        check_val("clr noacc", hits, 0);
        check_val("clr idle", in_ready, 1);
        run_sample("s9", 1024, 0, 0, 0);

        // reset in the middle of WAIT
        accept_only("r", 1024, 0, lat);
        check_val("r x", x_out, 1024);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_val("r x0", x_out, 0);
        check_val("r y0", y_out, 0);
        check_val("r start0", start_out, 0);
        check_val("r ready", in_ready, 1);
        run_sample("s10", 1024, 0, 0, 0);

        accept_only("t", 1024, 0, lat);
        check_val("t x", x_out, 1024);
`ifdef DEMOD_TIMEOUT_EN
        hits = 0;
        while (timeout_err !== 1'b1 && hits < 200) begin
            @(posedge clk);
            #1;
            hits++;
        end
        check_val("tmo lat", hits, 64);
        @(posedge clk);
        #1;
        check_val("tmo pulse", timeout_err, 0);
        check_val("tmo ready", in_ready, 1);
        run_sample("s11", 0, 1024, 0, 1024);
`else
        hits = 0;
        rdy  = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (timeout_err) hits++;
            if (in_ready) rdy++;
        end
        check_val("hold terr", hits, 0);
        check_val("hold ready", rdy, 0);
        check_val("hold x", x_out, 1024);
        arctan_valid = 1'b1;
        @(posedge clk);
        #1;
        arctan_valid = 1'b0;
        check_val("hold release", in_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demod_conj_mult.md
Name: demod_conj_mult

Overview:
- Stage directly upstream of the arctangent unit in the FM demodulator.
- Accepts one quantized I/Q sample per handshake and forms the conjugate product with the previously accepted sample: (i + jq)(ip − jqp).
- Presents x = Re and y = Im to the arctangent unit with a one-cycle start pulse.
- Holds x/y stable and accepts no new sample until the arctangent unit reports valid.

Parameters:
- DATA_WIDTH, 32, width of I/Q samples and of x/y.
- QUANT_BITS, 10, fixed-point fraction bits used by DEQ (1.0 = 1024).
- WAIT_TIMEOUT, 64, cycles to wait for arctan_valid before aborting. Used only with DEMOD_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_in  in  DATA_WIDTH  signed quantized in-phase sample
- q_in  in  DATA_WIDTH  signed quantized quadrature sample
- in_valid  in  1  sample present on i_in/q_in
- in_ready  out  1  block can accept a sample this cycle
- clear  in  1  zero the stored previous sample
- x_out  out  DATA_WIDTH  signed Re of conjugate product, to arctangent x
- y_out  out  DATA_WIDTH  signed Im of conjugate product, to arctangent y
- start_out  out  1  one-cycle pulse, x_out/y_out valid
- arctan_valid  in  1  arctangent result produced (releases WAIT)
- timeout_err  out  1  one-cycle pulse on WAIT abort (tied 0 without macro)

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE. prev_i, prev_q, product regs, x_out, y_out, start_out and timeout_err all 0. Reset overrides any state, including mid-WAIT.
- in_ready = (state==IDLE) && !clear. This is a combinational output.
- Accept = in_valid && in_ready. On accept: latch i_in/q_in into cur_i/cur_q, go to MULT.
- IDLE with clear=1: prev_i and prev_q set to 0. No accept that cycle; clear wins over in_valid. clear is ignored outside IDLE.
- MULT (1 cycle): register four products, each the low DATA_WIDTH bits of a signed multiply, then arithmetic shift right by QUANT_BITS (DEQ):
  - p_ii = DEQ(cur_i*prev_i)
  - p_qq = DEQ(cur_q*prev_q)
  - p_qi = DEQ(cur_q*prev_i)
  - p_iq = DEQ(cur_i*prev_q)
  - Go to SUM.
- SUM (1 cycle): x_out ← p_ii + p_qq, y_out ← p_qi − p_iq, both wrapping at DATA_WIDTH. prev_i/prev_q ← cur_i/cur_q. Go to ISSUE.
- ISSUE (1 cycle): start_out=1. Go to WAIT.
- WAIT: x_out/y_out held. On arctan_valid=1, return to IDLE the next cycle. arctan_valid outside WAIT is ignored.
- Latency: accept at edge N; x_out/y_out updated at edge N+2; start_out high during cycle N+3; earliest next accept at edge after arctan_valid.
- The first sample after reset or clear pairs with prev=0, so x=y=0.
- start_out and timeout_err are never high for more than one consecutive cycle.

Optional Feature:
- Macro DEMOD_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches WAIT_TIMEOUT with no arctan_valid, timeout_err pulses for one cycle and the FSM goes to IDLE. prev_i/prev_q keep the aborted sample. arctan_valid in the same cycle as the limit wins: normal exit, no error.
- Undefined: no counter. WAIT lasts until arctan_valid. timeout_err tied 0.

Decomposition:
- Shared package holds:
  - QUANT_BITS constant
  - DEQUANTIZE function (truncate, then arithmetic shift)
  - state enum typedef {IDLE, MULT, SUM, ISSUE, WAIT}
- One sub-module is natural: cmul_deq, a registered 4-product multiply/dequantize used in MULT. It is reusable by the downstream gain stage.

Test Plan:
- Reset, then accept (1024,0), then (1024,0), arctan_valid pulsed 5 cycles after each start -> first x=0,y=0; second x=1024,y=0; in_ready low from accept until after arctan_valid.
- prev (1024,0), accept (0,1024) -> x=0,y=1024. Then accept (−1024,0) -> x=0,y=1024.
- in_valid and clear both high in IDLE with prev (1024,0) -> no accept. Next accept (1024,0) -> x=0,y=0.
- reset low during WAIT -> next cycle IDLE, outputs 0, in_ready=1. Following sample (1024,0) gives x=0.
- DEMOD_TIMEOUT_EN, WAIT_TIMEOUT=64, arctan_valid never asserted -> timeout_err pulses 64 cycles after the start_out cycle, in_ready=1 the following cycle.
- Same setup without the macro -> block stays in WAIT for 1000 cycles, timeout_err stays 0.
